out_port: RTL and testbench

// - Memory-mapped output port: CPU side writes bytes to four external output channels.
// - Each channel drives its byte with a valid/ack handshake to the external world.
// - Sits beside the input port on the same 8-bit Address/data I/O bus.
// - Per-channel status: Busy, plus sticky Overflow and Timeout flags.

---
 rtl/out_port.sv | 167 ++++++++++++++++
 tb/tb_out_port.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/out_port.sv
// Memory-mapped four-channel output port with per-channel valid/ack handshake and sticky status.
// Optional handshake timeout is built only when OUTPORT_TIMEOUT_EN is defined.

module out_port #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned CNT_W          = 8
) (
   input  logic       clk,
   input  logic       Reset,
   input  logic       OUTportWrite,
   input  logic [7:0] Address,
   input  logic [7:0] Datain,
   output logic [7:0] OutExtWorld1,
   output logic [7:0] OutExtWorld2,
   output logic [7:0] OutExtWorld3,
   output logic [7:0] OutExtWorld4,
   output logic [3:0] OutValid,
   input  logic [3:0] OutAck,
   output logic [3:0] Busy,
   output logic [3:0] Overflow,
   output logic [3:0] Timeout
);

   // state   | meaning
   // IDLE    | channel empty, OutValid low, ack ignored
   // PEND    | byte presented, OutValid high, waiting for ack (or expiry)
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_PEND = 1'b1
   } ch_state_e;

   localparam logic [7:0] ADDR_CLR = 8'h04;

   if (TIMEOUT_CYCLES >= (64'd1 << CNT_W)) begin : g_bad_cnt_w
      $error("out_port: TIMEOUT_CYCLES does not fit in CNT_W bits");
   end

   ch_state_e  state_q [4];
   ch_state_e  state_d [4];
   logic [7:0] data_q  [4];
   logic [7:0] data_d  [4];
   logic [3:0] ovf_q;
   logic [3:0] ovf_d;
   logic [3:0] set_ovf;
   logic [3:0] wr_ch;
   logic       wr_clr;
   logic [3:0] pend;
   logic [3:0] expire;

   always_comb begin
      for (int k = 0; k < 4; k++) begin
         wr_ch[k] = OUTportWrite && (Address == 8'(k));
         pend[k]  = (state_q[k] == ST_PEND);
      end
      wr_clr = OUTportWrite && (Address == ADDR_CLR);
   end

`ifdef OUTPORT_TIMEOUT_EN
   // Down-counter loaded on every accepted write; expiry is terminal count without ack.
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] cnt_q [4];
   logic [CNT_W-1:0] cnt_d [4];
   logic [3:0]       accept;
   logic [3:0]       to_q;
   logic [3:0]       to_d;

   always_comb begin
      for (int k = 0; k < 4; k++) begin
         accept[k] = wr_ch[k] && (!pend[k] || OutAck[k]);
         expire[k] = pend[k] && !OutAck[k] && (cnt_q[k] == '0);
         cnt_d[k]  = cnt_q[k];
         if (accept[k]) begin
            cnt_d[k] = CNT_LOAD;
         end else if (pend[k] && (cnt_q[k] != '0)) begin
            cnt_d[k] = cnt_q[k] - CNT_W'(1);
         end
      end
      to_d = to_q;
      if (wr_clr) begin
         to_d = to_d & ~Datain[7:4];
      end
      to_d = to_d | expire;
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         for (int k = 0; k < 4; k++) begin
            cnt_q[k] <= '0;
         end
         to_q <= '0;
      end else begin
         for (int k = 0; k < 4; k++) begin
            cnt_q[k] <= cnt_d[k];
         end
         to_q <= to_d;
      end
   end

   assign Timeout = to_q;
`else
   assign expire  = 4'b0000;
   assign Timeout = 4'b0000;
`endif

   always_comb begin
      for (int k = 0; k < 4; k++) begin
         state_d[k] = state_q[k];
         data_d[k]  = data_q[k];
         set_ovf[k] = 1'b0;
         unique case (state_q[k])
            ST_IDLE: begin
               if (wr_ch[k]) begin
                  state_d[k] = ST_PEND;
                  data_d[k]  = Datain;
               end
            end
            ST_PEND: begin
               if (OutAck[k]) begin
                  // Ack and write together hand over with no gap in OutValid.
                  if (wr_ch[k]) begin
                     data_d[k] = Datain;
                  end else begin
                     state_d[k] = ST_IDLE;
                  end
               end else begin
                  set_ovf[k] = wr_ch[k];
                  if (expire[k]) begin
                     state_d[k] = ST_IDLE;
                  end
               end
            end
            default: state_d[k] = ST_IDLE;
         endcase
      end
      ovf_d = ovf_q;
      if (wr_clr) begin
         ovf_d = ovf_d & ~Datain[3:0];
      end
      ovf_d = ovf_d | set_ovf;
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         for (int k = 0; k < 4; k++) begin
            state_q[k] <= ST_IDLE;
            data_q[k]  <= 8'h00;
         end
         ovf_q <= '0;
      end else begin
         for (int k = 0; k < 4; k++) begin
            state_q[k] <= state_d[k];
            data_q[k]  <= data_d[k];
         end
         ovf_q <= ovf_d;
      end
   end

   assign OutExtWorld1 = data_q[0];
   assign OutExtWorld2 = data_q[1];
   assign OutExtWorld3 = data_q[2];
   assign OutExtWorld4 = data_q[3];
   assign OutValid     = pend;
   assign Busy         = pend;
   assign Overflow     = ovf_q;

endmodule

// File: tb/tb_out_port.sv
// Directed self-checking bench for out_port; timeout scenarios run when OUTPORT_TIMEOUT_EN is defined.

module tb_out_port;

   logic       clk = 1'b0;
   logic       Reset;
   logic       OUTportWrite;
   logic [7:0] Address;
   logic [7:0] Datain;
   logic [7:0] OutExtWorld1;
   logic [7:0] OutExtWorld2;
   logic [7:0] OutExtWorld3;
   logic [7:0] OutExtWorld4;
   logic [3:0] OutValid;
   logic [3:0] OutAck;
   logic [3:0] Busy;
   logic [3:0] Overflow;
   logic [3:0] Timeout;

   int n_checks = 0;
   int n_fail   = 0;

   out_port #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
      .clk          (clk),
      .Reset        (Reset),
      .OUTportWrite (OUTportWrite),
      .Address      (Address),
      .Datain       (Datain),
      .OutExtWorld1 (OutExtWorld1),
      .OutExtWorld2 (OutExtWorld2),
      .OutExtWorld3 (OutExtWorld3),
      .OutExtWorld4 (OutExtWorld4),
      .OutValid     (OutValid),
      .OutAck       (OutAck),
      .Busy         (Busy),
      .Overflow     (Overflow),
      .Timeout      (Timeout)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One bus write with optional simultaneous ack, then bus idle.
   task automatic wr(input logic [7:0] addr, input logic [7:0] data, input logic [3:0] ack);
      OUTportWrite = 1'b1;
      Address      = addr;
      Datain       = data;
      OutAck       = ack;
      tick();
      OUTportWrite = 1'b0;
      OutAck       = 4'b0000;
   endtask

   task automatic ack(input logic [3:0] a);
      OutAck = a;
      tick();
      OutAck = 4'b0000;
   endtask

   initial begin
      Reset        = 1'b1;
      OUTportWrite = 1'b0;
      Address      = 8'h00;
      Datain       = 8'h00;
      OutAck       = 4'b0000;
      tick();
      tick();
      Reset = 1'b0;
      chk("rst_valid", 32'(OutValid), 32'h0);
      chk("rst_ext1", 32'(OutExtWorld1), 32'h00);
      chk("rst_ext4", 32'(OutExtWorld4), 32'h00);
      chk("rst_ovf", 32'(Overflow), 32'h0);
      chk("rst_to", 32'(Timeout), 32'h0);

      // basic write then ack
      wr(8'h00, 8'hA5, 4'b0000);
      chk("wr1_ext1", 32'(OutExtWorld1), 32'hA5);
      chk("wr1_valid", 32'(OutValid), 32'h1);
      chk("wr1_busy", 32'(Busy), 32'h1);
      ack(4'b0001);
      chk("ack1_valid", 32'(OutValid), 32'h0);
      chk("ack1_ext1", 32'(OutExtWorld1), 32'hA5);
      ack(4'b0001);
      chk("idle_ack_valid", 32'(OutValid), 32'h0);

      // overflow on busy channel, then clear
      wr(8'h01, 8'h11, 4'b0000);
      wr(8'h01, 8'h22, 4'b0000);
      chk("ovf_ext2", 32'(OutExtWorld2), 32'h11);
      chk("ovf_flag", 32'(Overflow), 32'h2);
      chk("ovf_valid", 32'(OutValid), 32'h2);
      wr(8'h04, 8'h02, 4'b0000);
      chk("ovf_clr", 32'(Overflow), 32'h0);

      // write with same-cycle ack on channel 3
      wr(8'h02, 8'h30, 4'b0000);
      chk("ch3_pend_valid", 32'(OutValid), 32'h6);
      wr(8'h02, 8'h33, 4'b0100);
      chk("wack_ext3", 32'(OutExtWorld3), 32'h33);
      chk("wack_valid", 32'(OutValid), 32'h6);
      chk("wack_ovf", 32'(Overflow), 32'h0);
      ack(4'b0110);
      chk("ack23_valid", 32'(OutValid), 32'h0);
      chk("ack23_to", 32'(Timeout), 32'h0);

      // unmapped addresses
      wr(8'h07, 8'hFF, 4'b0000);
      wr(8'hFF, 8'h5C, 4'b0000);
      chk("unmap_valid", 32'(OutValid), 32'h0);
      chk("unmap_ext", {OutExtWorld1, OutExtWorld2, OutExtWorld3, OutExtWorld4}, 32'hA5113300);
      chk("unmap_ovf", 32'(Overflow), 32'h0);

      // back-to-back writes to all channels
      wr(8'h00, 8'h41, 4'b0000);
      wr(8'h01, 8'h42, 4'b0000);
      wr(8'h02, 8'h43, 4'b0000);
      wr(8'h03, 8'h44, 4'b0000);
      chk("b2b_valid", 32'(OutValid), 32'hF);
      chk("b2b_ext", {OutExtWorld1, OutExtWorld2, OutExtWorld3, OutExtWorld4}, 32'h41424344);
      ack(4'b1111);
      chk("b2b_ack_valid", 32'(OutValid), 32'h0);

`ifdef OUTPORT_TIMEOUT_EN
      // ack on the expiry edge is a success
      wr(8'h03, 8'h90, 4'b0000);
      for (int i = 0; i < 4; i++) tick();
      chk("exp_ack_pre", 32'(OutValid), 32'h8);
      ack(4'b1000);
      chk("exp_ack_valid", 32'(OutValid), 32'h0);
      chk("exp_ack_to", 32'(Timeout), 32'h0);

      // plain timeout: OutValid high 5 cycles
      wr(8'h03, 8'h99, 4'b0000);
      chk("to_c1", 32'(OutValid[3]), 32'h1);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("to_hold", 32'(OutValid[3]), 32'h1);
      end
      tick();
      chk("to_drop", 32'(OutValid[3]), 32'h0);
      chk("to_flag", 32'(Timeout), 32'h8);
      chk("to_ext4", 32'(OutExtWorld4), 32'h99);
      wr(8'h04, 8'h80, 4'b0000);
      chk("to_clr", 32'(Timeout), 32'h0);

      // set beats clear on the same edge
      wr(8'h03, 8'h9A, 4'b0000);
      for (int i = 0; i < 4; i++) tick();
      wr(8'h04, 8'h80, 4'b0000);
      chk("to_setwins", 32'(Timeout), 32'h8);
      chk("to_setwins_valid", 32'(OutValid), 32'h0);
`else
      // without timeout the channel waits indefinitely
      wr(8'h03, 8'h99, 4'b0000);
      for (int i = 0; i < 10; i++) tick();
      chk("noto_valid", 32'(OutValid), 32'h8);
      chk("noto_to", 32'(Timeout), 32'h0);
      ack(4'b1000);
      chk("noto_ack", 32'(OutValid), 32'h0);
`endif

      // reset while pending, with a write held during reset
      wr(8'h00, 8'h5A, 4'b0000);
      wr(8'h00, 8'h5B, 4'b0000);
      chk("pre_rst_ovf", 32'(Overflow), 32'h1);
      chk("pre_rst_ext1", 32'(OutExtWorld1), 32'h5A);
      Reset        = 1'b1;
      OUTportWrite = 1'b1;
      Address      = 8'h01;
      Datain       = 8'h77;
      tick();
      Reset        = 1'b0;
      OUTportWrite = 1'b0;
      chk("rst2_valid", 32'(OutValid), 32'h0);
      chk("rst2_ext1", 32'(OutExtWorld1), 32'h00);
      chk("rst2_ext2", 32'(OutExtWorld2), 32'h00);
      chk("rst2_ovf", 32'(Overflow), 32'h0);
      chk("rst2_to", 32'(Timeout), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
